// File: rtl/carry_chain_diff_serial_pkg.sv
// Shared definitions for the serial borrow-chain subtractor: slice width,
// FSM state encoding and the slice-index width helper.
package carry_chain_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice index for a W-bit operand; never narrower than 1 bit.
  function automatic int slice_idx_w(input int w);
    int n;
    n = $clog2(w / SLICE_W);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/carry_chain_diff_serial_if.sv
// Operand/result bus for carry_chain_diff_serial. Both directions use
// valid/ready: a beat moves on a rising edge where valid && ready are high;
// the source holds its payload stable while valid is high and ready is low.
interface carry_chain_diff_serial_if #(
  parameter int W = 64
);
  import carry_chain_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         b_out;
  logic         zero;
  logic         ovf;
  state_t       dbg_state;

  modport master (
    output in_valid, a, b, b_in, out_ready,
    input  in_ready, out_valid, diff, b_out, zero, ovf, dbg_state
  );

  modport slave (
    input  in_valid, a, b, b_in, out_ready,
    output in_ready, out_valid, diff, b_out, zero, ovf, dbg_state
  );

endinterface

// File: rtl/carry_chain_diff_serial_slice.sv
// One 8-bit slice of the borrow chain: {borrow_out, d} = a - b - borrow_in.
// Purely combinational; the top time-multiplexes a single instance.
module single_slice_borrow_gen
  import carry_chain_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_borrow,
  output logic [SLICE_W-1:0] o_d,
  output logic               o_borrow
);

  logic [SLICE_W:0] w_full;

  // The extra MSB of the 9-bit difference is set exactly when the slice borrows.
  assign w_full   = {1'b0, i_a} - {1'b0, i_b} - {{SLICE_W{1'b0}}, i_borrow};
  assign o_d      = w_full[SLICE_W-1:0];
  assign o_borrow = w_full[SLICE_W];

endmodule

// File: rtl/carry_chain_diff_serial.sv
// Multi-cycle W-bit subtractor: diff = a - b - b_in, one 8-bit slice per clock,
// LSB slice first. Define CARRY_CHAIN_DIFF_FLAGS_EN to build the zero/ovf flags.
module carry_chain_diff_serial
  import carry_chain_pkg::*;
#(
  parameter int W = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  carry_chain_diff_serial_if.slave  bus
);

  localparam int N      = W / SLICE_W;
  localparam int KW     = slice_idx_w(W);
  localparam int SHIFT  = $clog2(SLICE_W);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  generate
    if ((W % SLICE_W) != 0 || W < SLICE_W) begin : g_bad_width
      $error("carry_chain_diff_serial: W must be a non-zero multiple of 8");
    end
  endgenerate

  state_t              r_state;
  logic [KW-1:0]       r_k;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic                r_borrow;
  logic [W-1:0]        r_diff;
  logic                r_b_out;
  logic                r_out_valid;

  logic [KW+SHIFT-1:0] w_base;
  logic [SLICE_W-1:0]  w_a_sl;
  logic [SLICE_W-1:0]  w_b_sl;
  logic [SLICE_W-1:0]  w_d;
  logic                w_borrow;
  logic                w_last;
  logic                w_accept;

  assign w_base   = {r_k, {SHIFT{1'b0}}};
  assign w_a_sl   = r_a[w_base +: SLICE_W];
  assign w_b_sl   = r_b[w_base +: SLICE_W];
  assign w_last   = (r_k == K_LAST);
  assign w_accept = (r_state == IDLE) && bus.in_valid;

  single_slice_borrow_gen u_slice (
    .i_a      (w_a_sl),
    .i_b      (w_b_sl),
    .i_borrow (r_borrow),
    .o_d      (w_d),
    .o_borrow (w_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_borrow    <= 1'b0;
      r_diff      <= '0;
      r_b_out     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.b_in;
            r_k      <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_diff[w_base +: SLICE_W] <= w_d;
          r_borrow                  <= w_borrow;
          if (w_last) begin
            r_b_out     <= w_borrow;
            r_out_valid <= 1'b1;
            r_k         <= '0;
            r_state     <= DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          // Result stays frozen until the consumer takes it; new operands wait.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_k         <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CARRY_CHAIN_DIFF_FLAGS_EN
  logic r_zero_acc;
  logic r_zero;
  logic r_ovf;

  // The accumulator runs during RUN; the published flags only change on the
  // last slice so they hold steady for the whole DONE phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_acc <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_zero_acc <= 1'b1;
      end else if (r_state == RUN) begin
        r_zero_acc <= r_zero_acc & (w_d == '0);
        if (w_last) begin
          r_zero <= r_zero_acc & (w_d == '0);
          r_ovf  <= (r_a[W-1] != r_b[W-1]) && (w_d[SLICE_W-1] != r_a[W-1]);
        end
      end
    end
  end

  assign bus.zero = r_zero;
  assign bus.ovf  = r_ovf;
`else
  assign bus.zero = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.b_out     = r_b_out;
  assign bus.dbg_state = r_state;

endmodule
